load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/load_store_unit_if.sv | 28 ++
 rtl/lsu_align.sv | 51 +++++
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
// Holds the FSM state enum, the funct3 size/sign encodings, the byte-enable
// width and two small decode helpers used by the top level.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_W = 4;

    // Unsigned sizes only exist for loads; everything else outside B/H/W is illegal.
    function automatic logic f3_valid(input logic [2:0] f3, input logic wr);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !wr;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return off[0];
            F3_W:        return |off;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit.
// master (LSU): drives BusValid_o, BusWrite_o, BusAddr_o, BusWData_o, BusByteEn_o
//               and samples BusReady_i, BusRData_i.
// slave (memory): the mirror image.
interface load_store_unit_if
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic                  BusValid_o;
    logic                  BusWrite_o;
    logic [ADDR_WIDTH-1:0] BusAddr_o;
    logic [DATA_WIDTH-1:0] BusWData_o;
    logic [BE_W-1:0]       BusByteEn_o;
    logic                  BusReady_i;
    logic [DATA_WIDTH-1:0] BusRData_i;

    modport master (
        output BusValid_o, BusWrite_o, BusAddr_o, BusWData_o, BusByteEn_o,
        input  BusReady_i, BusRData_i
    );

    modport slave (
        input  BusValid_o, BusWrite_o, BusAddr_o, BusWData_o, BusByteEn_o,
        output BusReady_i, BusRData_i
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit.
// Store side: replicates the right-aligned store data across lanes and builds
//   byte enables from size and byte offset.
// Load side: shifts the bus word down by the byte offset and sign/zero extends.
// Ports: i_st_* / o_st_* store path, i_ld_* / o_ld_data load path.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            i_st_funct3,
    input  logic [1:0]            i_st_off,
    input  logic [DATA_WIDTH-1:0] i_st_data,
    output logic [DATA_WIDTH-1:0] o_st_lanes,
    output logic [BE_W-1:0]       o_st_be,
    input  logic [2:0]            i_ld_funct3,
    input  logic [1:0]            i_ld_off,
    input  logic [DATA_WIDTH-1:0] i_ld_word,
    output logic [DATA_WIDTH-1:0] o_ld_data
);
    logic [DATA_WIDTH-1:0] w_shifted;

    assign w_shifted = i_ld_word >> {i_ld_off, 3'b000};

    always_comb begin
        o_st_lanes = i_st_data;
        o_st_be    = 4'b1111;
        case (i_st_funct3)
            F3_B: begin
                o_st_lanes = {(DATA_WIDTH/8){i_st_data[7:0]}};
                o_st_be    = 4'b0001 << i_st_off;
            end
            F3_H: begin
                o_st_lanes = {(DATA_WIDTH/16){i_st_data[15:0]}};
                o_st_be    = 4'b0011 << {i_st_off[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        o_ld_data = w_shifted;
        case (i_ld_funct3)
            F3_B:  o_ld_data = {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
            F3_H:  o_ld_data = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
            F3_BU: o_ld_data = {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]};
            F3_HU: o_ld_data = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
            default: ;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns an execute-stage memory request into a single word
// bus transaction and returns the extended load result.
// Ports: clk_i/rst_i (sync, active-high); MemReq_i, MemWrite_i, Funct3_i,
//   ALUResult_i, WriteData_i from execute; Stall_o, Done_o, ReadData_o,
//   Misaligned_o back to the pipeline; bus = memory side (master modport).
// Optional: LSU_MISALIGN_TRAP_EN turns misaligned accesses into a trap
//   (no bus access, Misaligned_o=1). Otherwise the low address bits that make
//   the access misaligned are cleared and the access proceeds.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   MemReq_i,
    input  logic                   MemWrite_i,
    input  logic [2:0]             Funct3_i,
    input  logic [ADDR_WIDTH-1:0]  ALUResult_i,
    input  logic [DATA_WIDTH-1:0]  WriteData_i,
    output logic                   Stall_o,
    output logic                   Done_o,
    output logic [DATA_WIDTH-1:0]  ReadData_o,
    output logic                   Misaligned_o,
    load_store_unit_if.master      bus
);
    lsu_state_t            r_state, w_next;
    logic                  r_write;
    logic [2:0]            r_funct3;
    logic [1:0]            r_off;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BE_W-1:0]       r_be;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_req_valid;
    logic                  w_trap;
    logic [1:0]            w_off;
    logic                  w_capture;
    logic                  w_accept;
    logic                  w_in_access;
    logic [DATA_WIDTH-1:0] w_st_lanes;
    logic [BE_W-1:0]       w_st_be;
    logic [DATA_WIDTH-1:0] w_ld_data;

    assign w_req_valid = f3_valid(Funct3_i, MemWrite_i);

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_mis;
    assign w_trap = f3_misaligned(Funct3_i, ALUResult_i[1:0]);
    assign w_off  = ALUResult_i[1:0];
`else
    // Clear the offending offset bits: halfwords keep addr[1], words keep none.
    assign w_trap = 1'b0;
    always_comb begin
        w_off = ALUResult_i[1:0];
        case (Funct3_i)
            F3_H, F3_HU: w_off = {ALUResult_i[1], 1'b0};
            F3_W:        w_off = 2'b00;
            default: ;
        endcase
    end
`endif

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .i_st_funct3 (Funct3_i),
        .i_st_off    (w_off),
        .i_st_data   (WriteData_i),
        .o_st_lanes  (w_st_lanes),
        .o_st_be     (w_st_be),
        .i_ld_funct3 (r_funct3),
        .i_ld_off    (r_off),
        .i_ld_word   (bus.BusRData_i),
        .o_ld_data   (w_ld_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        Stall_o   = 1'b0;
        w_capture = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MemReq_i) begin
                    Stall_o   = 1'b1;
                    w_capture = 1'b1;
                    w_next    = (!w_req_valid || w_trap) ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                Stall_o = 1'b1;
                if (bus.BusReady_i) begin
                    w_accept = 1'b1;
                    w_next   = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request is latched once so the bus stays stable while memory stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_write  <= 1'b0;
            r_funct3 <= '0;
            r_off    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_rdata  <= '0;
        end else if (w_capture) begin
            r_write  <= MemWrite_i;
            r_funct3 <= Funct3_i;
            r_off    <= w_off;
            r_addr   <= {ALUResult_i[ADDR_WIDTH-1:2], 2'b00};
            r_wdata  <= w_st_lanes;
            r_be     <= w_st_be;
            r_rdata  <= '0;
        end else if (w_accept && !r_write) begin
            r_rdata  <= w_ld_data;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Invalid funct3 takes precedence: it reports no misalignment.
    always_ff @(posedge clk_i) begin
        if (rst_i)          r_mis <= 1'b0;
        else if (w_capture) r_mis <= w_req_valid & w_trap;
    end
    assign Misaligned_o = Done_o & r_mis;
`else
    assign Misaligned_o = 1'b0;
`endif

    assign w_in_access     = (r_state == S_ACCESS);
    assign Done_o          = (r_state == S_DONE);
    assign ReadData_o      = Done_o ? r_rdata : '0;

    assign bus.BusValid_o  = w_in_access;
    assign bus.BusWrite_o  = w_in_access & r_write;
    assign bus.BusAddr_o   = w_in_access ? r_addr  : '0;
    assign bus.BusWData_o  = w_in_access ? r_wdata : '0;
    assign bus.BusByteEn_o = w_in_access ? r_be    : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected bus requests
// and completions into queues; a negedge monitor pops and compares them.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          MemReq, MemWrite;
    logic [2:0]    f3;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          Stall_o, Done_o, Misaligned_o;
    logic [DW-1:0] ReadData_o;

    load_store_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    load_store_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .MemReq_i     (MemReq),
        .MemWrite_i   (MemWrite),
        .Funct3_i     (f3),
        .ALUResult_i  (addr),
        .WriteData_i  (wdata),
        .Stall_o      (Stall_o),
        .Done_o       (Done_o),
        .ReadData_o   (ReadData_o),
        .Misaligned_o (Misaligned_o),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] rdata;
        logic          mis;
    } rsp_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [DW-1:0] wd;
    } busx_t;

    rsp_t  rsp_q[$];
    busx_t bus_q[$];

    always @(negedge clk) begin : monitor
        rsp_t  r;
        busx_t b;
        if (Done_o) begin
            if (rsp_q.size() == 0) check("unexpected_done", 1, 0);
            else begin
                r = rsp_q.pop_front();
                check("done_rdata", ReadData_o, r.rdata);
                check("done_mis", Misaligned_o, r.mis);
            end
        end
        if (bus.BusValid_o && bus.BusReady_i) begin
            if (bus_q.size() == 0) check("unexpected_bus", 1, 0);
            else begin
                b = bus_q.pop_front();
                check("bus_write", bus.BusWrite_o, b.wr);
                check("bus_addr", bus.BusAddr_o, b.addr);
                if (b.wr) begin
                    check("bus_be", bus.BusByteEn_o, b.be);
                    check("bus_wdata", bus.BusWData_o, b.wd);
                end
            end
        end
    end

    task automatic access(input string tag, input logic wr, input logic [2:0] fn,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] rd, input int dly, input logic exp_bus,
                          input logic [AW-1:0] e_addr, input logic [3:0] e_be,
                          input logic [DW-1:0] e_wd, input logic [DW-1:0] e_rd,
                          input logic e_mis);
        rsp_t  r;
        busx_t b;
        @(posedge clk); #1;
        MemReq = 1'b1; MemWrite = wr; f3 = fn; addr = a; wdata = wd;
        r.rdata = e_rd; r.mis = e_mis;
        rsp_q.push_back(r);
        if (exp_bus) begin
            b.wr = wr; b.addr = e_addr; b.be = e_be; b.wd = e_wd;
            bus_q.push_back(b);
        end
        #1 check({tag, "_stall_c0"}, Stall_o, 1);
        @(posedge clk); #1;
        // Scramble request inputs: the DUT must work from its captured copy.
        MemReq = 1'b0; addr = ~a; wdata = ~wd; f3 = ~fn;
        if (exp_bus) begin
            for (int k = 0; k <= dly; k++) begin
                if (k > 0) begin @(posedge clk); #1; end
                bus.BusReady_i = (k == dly);
                bus.BusRData_i = (k == dly) ? rd : ~rd;
                #1;
                check({tag, "_valid"}, bus.BusValid_o, 1);
                check({tag, "_stall"}, Stall_o, 1);
                check({tag, "_addr_hold"}, bus.BusAddr_o, e_addr);
                if (wr) check({tag, "_wd_hold"}, bus.BusWData_o, e_wd);
                check({tag, "_no_early_done"}, Done_o, 0);
            end
            @(posedge clk); #1;
            bus.BusReady_i = 1'b0;
        end
        #1;
        check({tag, "_done"}, Done_o, 1);
        check({tag, "_stall_done"}, Stall_o, 0);
        check({tag, "_valid_done"}, bus.BusValid_o, 0);
        @(posedge clk); #2;
        check({tag, "_done_pulse"}, Done_o, 0);
    endtask

    initial begin
        rst = 1'b1; MemReq = 1'b0; MemWrite = 1'b0; f3 = '0; addr = '0; wdata = '0;
        bus.BusReady_i = 1'b0; bus.BusRData_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", Stall_o, 0);
        check("rst_done", Done_o, 0);
        check("rst_rdata", ReadData_o, 0);
        check("rst_mis", Misaligned_o, 0);
        check("rst_valid", bus.BusValid_o, 0);
        check("rst_write", bus.BusWrite_o, 0);
        check("rst_addr", bus.BusAddr_o, 0);
        check("rst_wdata", bus.BusWData_o, 0);
        check("rst_be", bus.BusByteEn_o, 0);
        rst = 1'b0;

        access("lw",    0, F3_W,  32'h100, 0, 32'hDEADBEEF, 0, 1, 32'h100, 0, 0, 32'hDEADBEEF, 0);
        access("lb",    0, F3_B,  32'h103, 0, 32'h80FFFFFF, 0, 1, 32'h100, 0, 0, 32'hFFFFFF80, 0);
        access("lbu",   0, F3_BU, 32'h103, 0, 32'h80FFFFFF, 0, 1, 32'h100, 0, 0, 32'h00000080, 0);
        access("sh",    1, F3_H,  32'h202, 32'h1234ABCD, 0, 0, 1, 32'h200, 4'b1100, 32'hABCDABCD, 0, 0);
        access("sb_d3", 1, F3_B,  32'h301, 32'h000000A5, 0, 3, 1, 32'h300, 4'b0010, 32'hA5A5A5A5, 0, 0);
        access("lh",    0, F3_H,  32'h102, 0, 32'h80011234, 1, 1, 32'h100, 0, 0, 32'hFFFF8001, 0);
        access("lhu",   0, F3_HU, 32'h106, 0, 32'h80011234, 0, 1, 32'h104, 0, 0, 32'h00008001, 0);
        access("sw",    1, F3_W,  32'h010, 32'hCAFEF00D, 0, 2, 1, 32'h010, 4'b1111, 32'hCAFEF00D, 0, 0);
        access("inv011", 0, 3'b011, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        access("inv_sbu", 1, F3_BU, 32'h100, 32'hFF, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        access("lw_mis", 0, F3_W, 32'h101, 0, 32'h11223344, 0, 0, 0, 0, 0, 0, 1);
        access("lh_mis", 0, F3_H, 32'h103, 0, 32'hAABBCCDD, 0, 0, 0, 0, 0, 0, 1);
        access("sh_mis", 1, F3_H, 32'h201, 32'h5678, 0, 0, 0, 0, 0, 0, 0, 1);
`else
        access("lw_mis", 0, F3_W, 32'h101, 0, 32'h11223344, 0, 1, 32'h100, 0, 0, 32'h11223344, 0);
        access("lh_mis", 0, F3_H, 32'h103, 0, 32'hAABBCCDD, 0, 1, 32'h100, 0, 0, 32'hFFFFAABB, 0);
        access("sh_mis", 1, F3_H, 32'h201, 32'h5678, 0, 0, 1, 32'h200, 4'b0011, 32'h56785678, 0, 0);
`endif

        // Reset while the bus is waiting: access is dropped, no completion.
        @(posedge clk); #1;
        MemReq = 1'b1; MemWrite = 1'b0; f3 = F3_W; addr = 32'h40;
        @(posedge clk); #1;
        MemReq = 1'b0; bus.BusReady_i = 1'b0;
        #1 check("rst_acc_valid_before", bus.BusValid_o, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_acc_valid", bus.BusValid_o, 0);
        check("rst_acc_stall", Stall_o, 0);
        check("rst_acc_done", Done_o, 0);
        repeat (3) @(posedge clk);
        #2 check("rst_acc_idle", Stall_o, 0);

        repeat (2) @(posedge clk);
        check("rsp_q_empty", rsp_q.size(), 0);
        check("bus_q_empty", bus_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
